// File: rtl/axi_lite_master_if.sv
// axi_lite_if: AXI4-Lite channel bundle (AR/R/AW/W/B) with 32-bit address
// and data. The master modport is used by axi_lite_master; the slave
// modport faces CLINT, UART and other peripherals behind the crossbar.
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: turns one LSU load/store request at a time into an
// AXI4-Lite read or write and returns read data plus an error flag.
// Every AXI valid/ready and every rsp_* output is decoded from registered
// state, so no input reaches an output combinationally.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort a stalled
// transaction after TIMEOUT_CYCLES cycles (simulation debug aid).
module axi_lite_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    axi_lite_if.master  m
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t      state, state_next;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        load_req;

    logic [31:0] rdata_q, rdata_next;
    logic        err_q, err_next;

    // Sticky per-channel handshake flags while in WR_REQ.
    logic        aw_done, aw_done_next;
    logic        w_done, w_done_next;

    // A zero or negative limit would make the watchdog meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("axi_lite_master: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        waiting;
    logic        timeout_hit;
    logic        timeout_fire;

    assign waiting     = (state != IDLE) && (state != RESP);
    assign timeout_hit = waiting && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, response capture and write-flag tracking.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next   = state;
        rdata_next   = rdata_q;
        err_next     = err_q;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        load_req     = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (req_valid) begin
                    load_req   = 1'b1;
                    state_next = req_we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (m.arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m.rvalid) begin
                    rdata_next = m.rdata;
                    err_next   = (m.rresp != 2'b00);
                    state_next = RESP;
                end
            end
            WR_REQ: begin
                // awvalid/wvalid are high exactly while their flag is clear,
                // so a ready on either channel here completes its handshake.
                aw_done_next = aw_done | m.awready;
                w_done_next  = w_done  | m.wready;
                if (aw_done_next && w_done_next) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m.bvalid) begin
                    err_next   = (m.bresp != 2'b00);
                    rdata_next = 32'h0;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // A handshake landing on the limit cycle still wins; only a state
        // that would otherwise stay put is aborted.
        if (timeout_hit && (state_next == state)) begin
            timeout_fire = 1'b1;
            state_next   = RESP;
            err_next     = 1'b1;
            rdata_next   = 32'h0;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
        end
`endif
    end

    // Control state and response registers.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            rdata_q <= rdata_next;
            err_q   <= err_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    // Request capture.
    // NOTE: these datapath registers have no reset; they are only observed
    // on the bus while a valid decoded from the reset state is high.
    always_ff @(posedge clk) begin
        if (load_req) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog counter: restarts on every state change, counts while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= 32'h0;
        end else if (state_next != state) begin
            to_cnt <= 32'h0;
        end else if (waiting) begin
            to_cnt <= to_cnt + 32'h1;
        end
    end

    // Debug report when the watchdog aborts a transaction.
    always_ff @(posedge clk) begin
        if (!reset && timeout_fire) begin
            $error("axi_lite_master: AXI transaction to 0x%08h timed out", addr_q);
        end
    end
`endif

    // Output decode from registered state and flags only.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;

        m.arvalid = (state == RD_ADDR);
        m.araddr  = addr_q;
        m.rready  = (state == RD_DATA);

        m.awvalid = (state == WR_REQ) && !aw_done;
        m.awaddr  = addr_q;
        m.wvalid  = (state == WR_REQ) && !w_done;
        m.wdata   = wdata_q;
        m.wstrb   = wstrb_q;
        m.bready  = (state == WR_RESP);
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: drives axi_lite_master against a configurable
// AXI4-Lite slave with a 16-word memory and programmable wait states and
// response codes. Expected responses, latencies and valid durations come
// from a transaction-level model: latency is 3 cycles plus the slave's
// wait states, a read returns the modelled word, a write returns zero.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    axi_lite_if m_if ();

    axi_lite_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m         (m_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
    logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;

    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        rd_pend, aw_got, w_got, b_pend;
    logic [31:0] rd_val, w_data_s;
    logic [3:0]  aw_idx, w_strb_s;
    logic [31:0] smem [16];

    logic        aw_hs, w_hs, wr_both;
    logic [3:0]  wr_idx, wr_strb;
    logic [31:0] wr_data;

    assign m_if.arready = m_if.arvalid && (ar_cnt >= cfg_ar_wait);
    assign m_if.rvalid  = rd_pend && (r_cnt >= cfg_r_wait);
    assign m_if.rdata   = rd_val;
    assign m_if.rresp   = cfg_rresp;
    assign m_if.awready = m_if.awvalid && (aw_cnt >= cfg_aw_wait);
    assign m_if.wready  = m_if.wvalid && (w_cnt >= cfg_w_wait);
    assign m_if.bvalid  = b_pend && (b_cnt >= cfg_b_wait);
    assign m_if.bresp   = cfg_bresp;

    assign aw_hs   = m_if.awvalid && m_if.awready;
    assign w_hs    = m_if.wvalid && m_if.wready;
    assign wr_both = (aw_got || aw_hs) && (w_got || w_hs);
    assign wr_idx  = aw_hs ? m_if.awaddr[5:2] : aw_idx;
    assign wr_data = w_hs ? m_if.wdata : w_data_s;
    assign wr_strb = w_hs ? m_if.wstrb : w_strb_s;

    always @(posedge clk) begin
        if (reset) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            rd_val <= 32'h0; w_data_s <= 32'h0; aw_idx <= 4'h0; w_strb_s <= 4'h0;
            for (int i = 0; i < 16; i++) smem[i] <= 32'hC0DE_0000 + 32'(i);
            smem[2] <= 32'h0000_0010;
        end else begin
            if (rd_pend) begin
                if (m_if.rvalid && m_if.rready) rd_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (m_if.arvalid && m_if.arready) begin
                ar_cnt  <= 0;
                rd_pend <= 1'b1;
                r_cnt   <= 0;
                rd_val  <= smem[m_if.araddr[5:2]];
            end else if (m_if.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (m_if.awvalid && !aw_hs) aw_cnt <= aw_cnt + 1;
            if (m_if.wvalid && !w_hs) w_cnt <= w_cnt + 1;
            if (aw_hs) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_idx <= m_if.awaddr[5:2];
            end
            if (w_hs) begin
                w_cnt <= 0; w_got <= 1'b1; w_data_s <= m_if.wdata; w_strb_s <= m_if.wstrb;
            end
            if (wr_both) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) smem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end else if (b_pend) begin
                if (m_if.bvalid && m_if.bready) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    int          ar_hi = 0, aw_hi = 0, w_hi = 0, bus_bad = 0;

    always @(negedge clk) begin
        if (m_if.arvalid) begin
            ar_hi++;
            if (m_if.araddr !== cur_addr) bus_bad++;
        end
        if (m_if.awvalid) begin
            aw_hi++;
            if (m_if.awaddr !== cur_addr) bus_bad++;
        end
        if (m_if.wvalid) begin
            w_hi++;
            if (m_if.wdata !== cur_wdata || m_if.wstrb !== cur_wstrb) bus_bad++;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem [16];

    task automatic mdl_init();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'hC0DE_0000 + 32'(i);
        mdl_mem[2] = 32'h0000_0010;
    endtask

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] word;
        word = mdl_mem[addr[5:2]];
        for (int b = 0; b < 4; b++)
            if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
        mdl_mem[addr[5:2]] = word;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar_w, r_w, aw_w, w_w, b_w;
        logic [1:0]  rresp, bresp;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat, exp_ar, exp_aw, exp_w;
    } vec_t;

    // One request/response exchange with all checks against v's expectations.
    task automatic run_txn(input vec_t v, input string tag);
        int  a0, aw0, w0, lat;
        bit  ok;
        @(negedge clk);
        cfg_ar_wait = v.ar_w; cfg_r_wait = v.r_w;
        cfg_aw_wait = v.aw_w; cfg_w_wait = v.w_w; cfg_b_wait = v.b_w;
        cfg_rresp = v.rresp; cfg_bresp = v.bresp;
        cur_addr = v.addr; cur_wdata = v.wdata; cur_wstrb = v.wstrb;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        a0 = ar_hi; aw0 = aw_hi; w0 = w_hi;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, ".accept"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; break; end
        end
        check({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, ".err"}, 32'(rsp_err), 32'(v.exp_err));
        for (int i = 0; i < v.hold; i++) begin
            check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            check({tag, ".hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_rdata"}, rsp_rdata, v.exp_rdata);
            check({tag, ".hold_err"}, 32'(rsp_err), 32'(v.exp_err));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".req_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, ".rsp_valid_after"}, 32'(rsp_valid), 32'd0);
        check({tag, ".arvalid_cycles"}, 32'(ar_hi - a0), 32'(v.exp_ar));
        check({tag, ".awvalid_cycles"}, 32'(aw_hi - aw0), 32'(v.exp_aw));
        check({tag, ".wvalid_cycles"}, 32'(w_hi - w0), 32'(v.exp_w));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".arvalid"}, 32'(m_if.arvalid), 32'd0);
        check({tag, ".rready"}, 32'(m_if.rready), 32'd0);
        check({tag, ".awvalid"}, 32'(m_if.awvalid), 32'd0);
        check({tag, ".wvalid"}, 32'(m_if.wvalid), 32'd0);
        check({tag, ".bready"}, 32'(m_if.bready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs [8];
        vec_t v;
        int   idx;
        bit   ok;

        //          we   addr           wdata          strb     ar r aw w b  rresp  bresp  hold exp_rdata      err lat ar aw w
        vecs[0] = '{1'b0, 32'hA000_0048, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0000_0010, 1'b0, 3, 1, 0, 0};
        vecs[1] = '{1'b1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, 0, 0, 0, 2, 0, 2'b00, 2'b00, 0, 32'h0,         1'b0, 5, 0, 1, 3};
        vecs[2] = '{1'b0, 32'h0000_03F8, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'hC0DE_0041, 1'b0, 3, 1, 0, 0};
        vecs[3] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1100, 0, 0, 3, 0, 1, 2'b00, 2'b10, 0, 32'h0,         1'b1, 7, 0, 4, 1};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1, 2, 0, 0, 0, 2'b11, 2'b00, 0, 32'h1234_0004, 1'b1, 6, 2, 0, 0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5, 32'hC0DE_0000, 1'b0, 3, 1, 0, 0};
        vecs[6] = '{1'b1, 32'h8000_003C, 32'hAABB_CCDD, 4'b1111, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2, 32'h0,         1'b0, 4, 0, 2, 2};
        vecs[7] = '{1'b0, 32'h0000_003C, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 32'hAABB_CCDD, 1'b1, 3, 1, 0, 0};

        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
        cur_addr = 32'h0; cur_wdata = 32'h0; cur_wstrb = 4'h0;
        mdl_init();

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset.rsp_rdata", rsp_rdata, 32'h0);
        check("reset.rsp_err", 32'(rsp_err), 32'd0);

        // Directed table.
        for (int k = 0; k < 8; k++) begin
            run_txn(vecs[k], $sformatf("vec%0d", k));
            if (vecs[k].we) mdl_write(vecs[k].addr, vecs[k].wdata, vecs[k].wstrb);
        end

        // Randomised traffic against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            idx       = $urandom_range(0, 15);
            v.we      = 1'($urandom_range(0, 1));
            v.addr    = ($urandom() & 32'hFFFF_FFC3) | (32'(idx) << 2);
            v.wdata   = $urandom();
            v.wstrb   = 4'($urandom_range(0, 15));
            v.ar_w    = $urandom_range(0, 3);
            v.r_w     = $urandom_range(0, 3);
            v.aw_w    = $urandom_range(0, 3);
            v.w_w     = $urandom_range(0, 3);
            v.b_w     = $urandom_range(0, 3);
            v.rresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.bresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.hold    = $urandom_range(0, 2);
            if (v.we) begin
                v.exp_rdata = 32'h0;
                v.exp_err   = (v.bresp != 2'b00);
                v.exp_lat   = 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
                v.exp_ar    = 0;
                v.exp_aw    = v.aw_w + 1;
                v.exp_w     = v.w_w + 1;
            end else begin
                v.exp_rdata = mdl_mem[idx];
                v.exp_err   = (v.rresp != 2'b00);
                v.exp_lat   = 3 + v.ar_w + v.r_w;
                v.exp_ar    = v.ar_w + 1;
                v.exp_aw    = 0;
                v.exp_w     = 0;
            end
            run_txn(v, $sformatf("rnd%0d", n));
            if (v.we) mdl_write(v.addr, v.wdata, v.wstrb);
        end

        check("bus_stability_errors", 32'(bus_bad), 32'd0);

        // Reset while the master waits in RD_DATA.
        @(negedge clk);
        cfg_ar_wait = 0; cfg_r_wait = 6; cfg_rresp = 2'b00;
        cur_addr = 32'h0000_0008;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0008;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_if.rready) begin ok = 1'b1; break; end
        end
        check("rst_mid.reached_rd_data", 32'(ok), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid");
        reset = 1'b0;
        mdl_init();
        cfg_r_wait = 0;
        run_txn(vecs[0], "after_rst");

`ifdef AXI_MASTER_TIMEOUT_EN
        // Slave never raises arready: watchdog must abort after 8 cycles.
        begin
            int a0, lat;
            @(negedge clk);
            cfg_ar_wait = 100000;
            cur_addr = 32'h0000_0004;
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0004;
            a0 = ar_hi;
            @(posedge clk);
            #1 req_valid = 1'b0;
            lat = 0;
            for (int i = 1; i <= 50; i++) begin
                @(negedge clk);
                if (rsp_valid) begin lat = i; break; end
            end
            check("timeout.rsp_seen", 32'(lat != 0), 32'd1);
            check("timeout.arvalid_cycles", 32'(ar_hi - a0), 32'd8);
            check("timeout.err", 32'(rsp_err), 32'd1);
            check("timeout.rdata", rsp_rdata, 32'h0);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that converts a single-outstanding load/store request from the core's LSU into AXI4-Lite read or write transactions and returns the data and error status. It sits between the LSU and the AXI4-Lite crossbar and drives slaves such as the CLINT and UART through the `axi_lite_if.master` modport. Exactly one transaction is in flight at a time.

## Interface

- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles; used only when `AXI_MASTER_TIMEOUT_EN` is defined.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, 1: request valid.
- `req_ready`, out, 1: request accepted when high together with `req_valid`.
- `req_we`, in, 1: 1 selects write, 0 selects read.
- `req_addr`, in, 32: byte address, passed unmodified to `araddr`/`awaddr`.
- `req_wdata`, in, 32: write data.
- `req_wstrb`, in, 4: write byte strobes.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response consumed.
- `rsp_rdata`, out, 32: read data; 0 for writes.
- `rsp_err`, out, 1: the slave returned a response other than OKAY (2'b00), or the watchdog fired.
- `m`, `axi_lite_if.master`, –: AR/R/AW/W/B channels, 32-bit address and data.

## Operation

- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr, wdata, wstrb and we, then go to RD_ADDR if `req_we`=0, otherwise to WR_REQ.
- RD_ADDR: `arvalid`=1 with a stable `araddr`. On `arready`, go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, latch `rdata` and set `err` = (`rresp` != 0). Go to RESP.
- WR_REQ: `awvalid` and `wvalid` assert together. Two sticky flags, `aw_done` and `w_done`, record each handshake. Each valid drops in the cycle after its own handshake. The handshakes can complete in either order or in the same cycle. When both flags are set, clear them and go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, set `err` = (`bresp` != 0), set `rdata` to 0, and go to RESP.
- RESP: `rsp_valid`=1 with stable `rsp_rdata`/`rsp_err`. On `rsp_ready`, go to IDLE.
- All AXI valid/ready outputs and all `rsp_*` outputs are decoded from registered state and flags only. There is no combinational path from any input to any output.
- AXI address and data outputs remain stable while their valid is high. `wstrb` is passed through unchanged.
- Reset: state goes to IDLE; `arvalid`, `awvalid`, `wvalid`, `rready`, `bready` and `rsp_valid` are 0; `rsp_rdata` = 0; `rsp_err` = 0; both flags are cleared. `req_ready` is 1 from the first cycle after reset. A reset asserted mid-transaction abandons the transaction with no response; the interconnect is reset on the same signal.

## Timing

- Read, zero-wait slave: request accepted at edge N; `arvalid` high in cycle N+1; `rready` high in cycle N+2; `rsp_valid` high in cycle N+3.
- Write, zero-wait slave: AW and W handshake in cycle N+1; `bready` high in cycle N+2; `rsp_valid` high in cycle N+3.
- Back-to-back throughput: one request per 4 cycles minimum, because `rsp_ready` is sampled in RESP and IDLE takes one cycle.
- A slave stall extends the current state indefinitely when the watchdog is compiled out.

## Configuration

- `AXI_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to any state other than IDLE or RESP and increments each cycle the block remains in RD_ADDR, RD_DATA, WR_REQ or WR_RESP.
  - When the counter reaches `TIMEOUT_CYCLES`, all AXI valids and readies drop, the flags clear, the block goes to RESP with `rsp_err`=1 and `rsp_rdata`=0, and `$error` is issued.
  - A late slave response is not accepted. This mode is for simulation debug only.
- `AXI_MASTER_TIMEOUT_EN` undefined: no counter and no abort path; the `TIMEOUT_CYCLES` parameter is ignored.

## Test plan

- Read of 0xa0000048 from a CLINT model with `mtime`=0x0000_0000_0000_0010 and zero wait -> `rsp_valid` 3 cycles after acceptance, `rsp_rdata` = 0x10, `rsp_err` = 0.
- Write to 0xa00003f8 with wdata=0x41, wstrb=4'b0001; slave delays `wready` by 2 cycles after `awready` -> `awvalid` drops after 1 cycle, `wvalid` holds 3 cycles, `rsp_err` = 0, `rsp_rdata` = 0.
- Write to a slave returning `bresp`=2'b10, and a read from a slave returning `rresp`=2'b11 -> `rsp_err` = 1 in both cases.
- `rsp_ready` held low for 5 cycles -> `rsp_valid`, `rsp_rdata` and `rsp_err` remain stable, and `req_ready` stays 0 until the cycle after `rsp_ready`.
- Reset asserted while in RD_DATA -> on the next cycle all AXI valids and readies are 0, `rsp_valid` = 0 and `req_ready` = 1.
- With `AXI_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, against a slave that never asserts `arready` -> `arvalid` drops after 8 cycles in RD_ADDR, and `rsp_valid`=1 with `rsp_err`=1.
